// File: rtl/step_controller.sv
// Single-step / auto-run clock generator for the Mips core.
// Debounces the step key, paces auto-run, emits cpu_clock steps.
//
// Ports:
//   clock       board clock (all state on rising edge)
//   reset       asynchronous active-low reset
//   key_step_n  raw bouncing step key, active-low, async
//   run_en      raw run switch, 1 = auto-run, async
//   cpu_clock   registered clock to the core
//   step_pulse  one-cycle strobe on each cpu_clock rise
//   busy        high while a step is in progress
//   step_count  number of steps issued (wraps)
module step_controller #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned PULSE_CYCLES    = 4,
    parameter int unsigned RUN_PERIOD      = 25000000,
    parameter int unsigned COUNT_W         = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               key_step_n,
    input  logic               run_en,
    output logic               cpu_clock,
    output logic               step_pulse,
    output logic               busy,
    output logic [COUNT_W-1:0] step_count
);

    localparam int DB_W =
        (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RUN_W =
        (RUN_PERIOD > 1) ? $clog2(RUN_PERIOD) : 1;
    localparam int PUL_W =
        (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;

    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(RUN_PERIOD - 1);
    localparam logic [PUL_W-1:0] PUL_LAST = PUL_W'(PULSE_CYCLES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HIGH = 2'd1;
    localparam logic [1:0] S_LOW  = 2'd2;

    logic [1:0]       key_sync;
    logic [1:0]       run_sync;
    logic             key_s;
    logic             run_s;
    logic             key_db;
    logic             key_db_d;
    logic [DB_W-1:0]  db_cnt;
    logic [RUN_W-1:0] run_cnt;
    logic [PUL_W-1:0] pul_cnt;
    logic [1:0]       state;
    logic             press;
    logic             tick;
    logic             req;

    assign key_s = key_sync[1];
    assign run_s = run_sync[1];

    // Key syncs to "released" so reset never looks like a press.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            key_sync <= 2'b11;
            run_sync <= 2'b00;
        end else begin
            key_sync <= {key_sync[0], key_step_n};
            run_sync <= {run_sync[0], run_en};
        end
    end

    // Any cycle agreeing with the stable level restarts the count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            key_db   <= 1'b1;
            key_db_d <= 1'b1;
            db_cnt   <= '0;
        end else begin
            key_db_d <= key_db;
            if (key_s == key_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                key_db <= key_s;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    assign press = key_db_d & ~key_db;

    // Held at zero outside run mode so each run starts a full period.
    assign tick = run_s && (run_cnt == RUN_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            run_cnt <= '0;
        end else if (!run_s || tick) begin
            run_cnt <= '0;
        end else begin
            run_cnt <= run_cnt + RUN_W'(1);
        end
    end

    assign req = run_s ? tick : press;

    // Requests only take effect in IDLE, so those arriving
    // mid-step are dropped rather than queued.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            pul_cnt    <= '0;
            cpu_clock  <= 1'b0;
            step_pulse <= 1'b0;
            busy       <= 1'b0;
            step_count <= '0;
        end else begin
            step_pulse <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (req) begin
                        state      <= S_HIGH;
                        pul_cnt    <= '0;
                        cpu_clock  <= 1'b1;
                        step_pulse <= 1'b1;
                        busy       <= 1'b1;
                        step_count <= step_count + COUNT_W'(1);
                    end
                end
                S_HIGH: begin
                    if (pul_cnt == PUL_LAST) begin
                        state     <= S_LOW;
                        pul_cnt   <= '0;
                        cpu_clock <= 1'b0;
                    end else begin
                        pul_cnt <= pul_cnt + PUL_W'(1);
                    end
                end
                S_LOW: begin
                    if (pul_cnt == PUL_LAST) begin
                        state   <= S_IDLE;
                        pul_cnt <= '0;
                        busy    <= 1'b0;
                    end else begin
                        pul_cnt <= pul_cnt + PUL_W'(1);
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    pul_cnt   <= '0;
                    cpu_clock <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/step_controller.md
Name: step_controller

Overview:
- Front end of the FPGA top, directly upstream of the Mips core.
- Turns a raw, bouncing, active-low pushbutton into clean single-step clock pulses on `cpu_clock`, which drives the core's clock input.
- Also provides an auto-run mode, selected by a switch, that issues steps at a fixed rate.
- Counts issued steps so the top can show progress on the hex displays.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable board-clock cycles required to accept a button level change (10 ms at 50 MHz).
- PULSE_CYCLES, 4, board-clock cycles `cpu_clock` stays high, and then stays low, per step.
- RUN_PERIOD, 25000000, board-clock cycles between auto-run step requests; must be ≥ 2*PULSE_CYCLES+1.
- COUNT_W, 32, width of step_count.

Ports:
- clock  input  1  board clock; all state is on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- key_step_n  input  1  raw step button, active-low, asynchronous to clock, bouncing.
- run_en  input  1  raw slide switch: 1 = auto-run, 0 = single-step; asynchronous to clock.
- cpu_clock  output  1  registered clock to the Mips core.
- step_pulse  output  1  one-cycle strobe, coincident with each `cpu_clock` rising edge.
- busy  output  1  high while a step is in progress (HIGH or LOW state).
- step_count  output  COUNT_W  number of steps issued; wraps modulo 2^COUNT_W.

Behaviour:

Reset (reset=0, asynchronous):
- cpu_clock=0, step_pulse=0, busy=0, step_count=0.
- State=IDLE; all timers=0.
- Synchronizer and debounced key flops reset to 1 (released); run_en synchronizer resets to 0.
- Reset asserted mid-step aborts the step immediately; cpu_clock drops without waiting for a clock edge.

Input synchronization:
- key_step_n and run_en each pass through a 2-flop synchronizer.
- Only the synchronized versions (key_s, run_s) are used downstream.

Debounce:
- Stable level key_db, reset value 1.
- The counter increments each cycle while key_s != key_db.
- The counter clears to 0 on any cycle where key_s == key_db, so a bounce restarts the count.
- When the counter reaches DEBOUNCE_CYCLES-1 with key_s still != key_db, key_db takes key_s and the counter clears.
- press = key_db 1→0 transition, a one-cycle internal event. Release generates nothing.

Auto-run timer:
- While run_s=1, the timer counts 0..RUN_PERIOD-1 and wraps.
- tick asserts for one cycle when the timer equals RUN_PERIOD-1.
- While run_s=0, the timer is held at 0 and no ticks occur.

Request:
- req = (run_s=0 AND press) OR (run_s=1 AND tick).
- Presses are ignored in run mode.

FSM (IDLE, HIGH, LOW):
- IDLE:
  - cpu_clock=0, busy=0.
  - On req, go to HIGH next cycle: cpu_clock=1, step_pulse=1 for that first HIGH cycle only, step_count+1.
- HIGH:
  - cpu_clock=1 for exactly PULSE_CYCLES cycles, then go to LOW.
- LOW:
  - cpu_clock=0 for exactly PULSE_CYCLES cycles, then go to IDLE.
- busy=1 in HIGH and LOW.

Timing and boundary rules:
- Latency: cpu_clock rises on the cycle after req.
- req while busy=1 is dropped, not queued. This applies to both presses and ticks.
- run_en toggling mid-step never truncates a step; the current step always completes.
- run_en 0→1 restarts the timer from 0, so the first tick comes RUN_PERIOD cycles after run_s rises.
- step_count at all-ones wraps to 0 on the next step.
- Outputs are registered; no combinational path from any input to any output.

Test Plan (DEBOUNCE_CYCLES=4, PULSE_CYCLES=2, RUN_PERIOD=8, COUNT_W=8):
1. Reset: hold reset=0 with key_step_n=0 and run_en=1 → cpu_clock=0, busy=0, step_count=0 throughout; no step_pulse.
2. Clean press: run_en=0; drive key_step_n low and hold 10 cycles → exactly one step_pulse. Then cpu_clock=1 for 2 cycles, cpu_clock=0 for 2 cycles, busy=1 for 4 cycles, step_count=1. Releasing the key produces no step.
3. Bounce: key_step_n toggles every 2 cycles for 20 cycles, then stays high → no step, step_count stays 0. The same bounce followed by a 6-cycle low hold → exactly one step.
4. Auto-run: run_en=1 for 40 cycles, with key_step_n pulsed low for 6 cycles in the middle → steps start every 8 cycles, step_count=4 or 5 as computed from the run_s rise. The key press adds no steps.
5. Mid-step events: trigger a step, then switch run_en 0→1 during HIGH → the step completes with full 2+2 cycles. Next, trigger a step and assert reset during HIGH → cpu_clock=0 asynchronously and step_count=0.
6. Wrap: preload to 255 by issuing 255 steps, then one more step → step_count=0 and step_pulse still asserted.
